dmem_hs: RTL

- Next-generation data memory for the core's MEM stage. Replaces the combinational-read byte array with a synchronous, word-organised store behind a valid/ready request/response handshake.
- Adds parametrised width, size and response latency, unsigned loads, and misaligned/out-of-range fault reporting.
- Serves one request at a time; the LSU stalls on req_ready/resp_valid.

---
 rtl/dmem_hs.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dmem_hs.sv
// Word-organised synchronous data memory behind a valid/ready request/response
// handshake; one outstanding request, fixed response latency, fault reporting.
module dmem_hs #(
    parameter int XLEN     = 64,
    parameter int MEM_SIZE = 65536,
    parameter int LATENCY  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);
    localparam int NB    = XLEN / 8;
    localparam int OW    = $clog2(NB);
    localparam int DEPTH = MEM_SIZE / NB;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      cnt_reg, cnt_next;
    logic            rdy_reg;
    logic [2:0]      op_reg;
    logic [OW-1:0]   off_reg;
    logic            we_reg;
    logic            err_reg;

    logic            accept;
    logic [3:0]      size;
    logic [7:0]      mask8;
    logic            misaligned, out_of_range, illegal, fault;
    logic [AW-1:0]   widx;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wdata_sh;
    logic            wr_en;
    logic [XLEN-1:0] rd_word;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ext;

    assign req_ready = rdy_reg && (state_reg == IDLE);
    assign accept    = req_valid && req_ready;
    assign widx      = req_addr[OW+AW-1:OW];

    always_comb begin
        size  = 4'd1 << req_op[1:0];
        mask8 = 8'hFF;
        case (req_op[1:0])
            2'd0:    mask8 = 8'h01;
            2'd1:    mask8 = 8'h03;
            2'd2:    mask8 = 8'h0F;
            default: mask8 = 8'hFF;
        endcase
        misaligned   = (req_addr & XLEN'(size - 4'd1)) != '0;
        // Full-width compare so high address bits never alias into the array.
        out_of_range = req_addr >= XLEN'(MEM_SIZE);
        illegal      = (req_op == 3'b111) || (req_we && req_op[2]) ||
                       ((XLEN == 32) && ((req_op == 3'b011) || (req_op == 3'b110)));
        fault        = misaligned || out_of_range || illegal;
        be           = NB'(mask8) << req_addr[OW-1:0];
        wdata_sh     = req_wdata << {req_addr[OW-1:0], 3'b000};
        wr_en        = accept && req_we && !fault;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] ram [DEPTH];
            logic [7:0] rd_byte_reg;
            always_ff @(posedge clk) begin
                if (wr_en && be[gi]) begin
                    ram[widx] <= wdata_sh[gi*8 +: 8];
                end
                if (accept) begin
                    rd_byte_reg <= ram[widx];
                end
            end
            assign rd_word[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 3'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 3'd1) begin
                    state_next = RESP;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            rdy_reg   <= 1'b0;
            op_reg    <= 3'd0;
            off_reg   <= '0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rdy_reg   <= 1'b1;
            if (accept) begin
                op_reg  <= req_op;
                off_reg <= req_addr[OW-1:0];
                we_reg  <= req_we;
                err_reg <= fault;
            end
        end
    end

    assign shifted = rd_word >> {off_reg, 3'b000};

    always_comb begin
        ext = shifted;
        case (op_reg)
            3'b000:  ext = XLEN'($signed(shifted[7:0]));
            3'b001:  ext = XLEN'($signed(shifted[15:0]));
            3'b010:  ext = XLEN'($signed(shifted[31:0]));
            3'b100:  ext = XLEN'(shifted[7:0]);
            3'b101:  ext = XLEN'(shifted[15:0]);
            3'b110:  ext = XLEN'(shifted[31:0]);
            default: ext = shifted;
        endcase
    end

    // Outputs gated by state so an async reset clears them immediately.
    assign resp_valid = (state_reg == RESP);
    assign resp_err   = resp_valid && err_reg;
    assign resp_rdata = (resp_valid && !err_reg && !we_reg) ? ext : '0;

`ifdef DEBUG
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            $display("dmem_hs accept addr=%h op=%03b we=%b data=%h", req_addr, req_op, req_we, req_wdata);
        end
        if (rst_n && resp_valid && resp_ready) begin
            $display("dmem_hs resp rdata=%h err=%b", resp_rdata, resp_err);
        end
    end
`endif
endmodule
